// File: rtl/div_arbiter_pkg.sv
// Shared types for the arbitrated divider.
// FSM state encoding and round-robin pointer width helper.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    RESP
  } state_t;

  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// done/quot/rem present the final step combinationally.
module div_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] r;
  logic [DW-1:0] q;
  logic [DW-1:0] d;
  logic [CW-1:0] cnt;
  logic [DW:0]   rs;
  logic [DW:0]   sub;
  logic          ge;
  logic [DW-1:0] r_n;
  logic [DW-1:0] q_n;
  logic          unused_bits;

  // A zero divisor always subtracts, giving all-ones and rem = a.
  always_comb begin
    rs  = {r, q[DW-1]};
    ge  = (rs >= {1'b0, d});
    sub = rs - {1'b0, d};
    r_n = ge ? sub[DW-1:0] : rs[DW-1:0];
    q_n = {q[DW-2:0], ge};
  end

  assign unused_bits = sub[DW];
  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));
  assign quot = q_n;
  assign rem  = r_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      r   <= '0;
      q   <= a;
      d   <= b;
      cnt <= CW'(DW);
    end else if (busy) begin
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider.
// DIV_ARBITER_DBZ_EN adds resp_dbz and a 1-cycle zero-divisor path.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*DATAWIDTH-1:0]   req_a,
  input  logic [NREQ*DATAWIDTH-1:0]   req_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [rr_width(NREQ)-1:0]   resp_id,
  output logic [DATAWIDTH-1:0]        resp_quot,
  output logic [DATAWIDTH-1:0]        resp_rem
`ifdef DIV_ARBITER_DBZ_EN
  ,
  output logic                        resp_dbz
`endif
);

  localparam int DW = DATAWIDTH;
  localparam int IW = rr_width(NREQ);
  localparam logic [IW:0] NR = (IW + 1)'(NREQ);

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] cur_id;
  logic [IW-1:0] g;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  logic [NREQ-1:0] rot;
  logic [DW-1:0] a_sel;
  logic [DW-1:0] b_sel;
  logic          hs;
  logic          start;
  logic          seq_busy;
  logic          seq_done;
  logic [DW-1:0] seq_quot;
  logic [DW-1:0] seq_rem;

  // Rotate requests so bit 0 is the requester at rr.
  always_comb begin
    rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (rr == IW'(j)) begin
        for (int i = 0; i < NREQ; i++) begin
          rot[i] = req_valid[(i + j) % NREQ];
        end
      end
    end
  end

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, rr} + {1'b0, off};
    g   = (sum >= NR) ? IW'(sum - NR) : sum[IW-1:0];
  end

  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g == IW'(i)) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
        req_ready[i] = (state == IDLE) && (|req_valid);
      end
    end
  end

  assign hs = (state == IDLE) && (|req_valid);

`ifdef DIV_ARBITER_DBZ_EN
  assign start = hs && (b_sel != '0) && !seq_busy;
`else
  assign start = hs && !seq_busy;
`endif

  div_seq #(
    .DW(DW)
  ) u_seq (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a_sel),
    .b    (b_sel),
    .busy (seq_busy),
    .done (seq_done),
    .quot (seq_quot),
    .rem  (seq_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= '0;
      cur_id     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_quot  <= '0;
      resp_rem   <= '0;
`ifdef DIV_ARBITER_DBZ_EN
      resp_dbz   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            cur_id <= g;
`ifdef DIV_ARBITER_DBZ_EN
            if (b_sel == '0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_id    <= g;
              resp_quot  <= '1;
              resp_rem   <= a_sel;
              resp_dbz   <= 1'b1;
            end else begin
              state <= DIVIDE;
            end
`else
            state <= DIVIDE;
`endif
          end
        end
        DIVIDE: begin
          if (seq_done) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_id    <= cur_id;
            resp_quot  <= seq_quot;
            resp_rem   <= seq_rem;
`ifdef DIV_ARBITER_DBZ_EN
            resp_dbz   <= 1'b0;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            rr <= (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter (DATAWIDTH=8, NREQ=2).
// Reference model: round-robin grant search plus integer / and %.
module tb_div_arbiter;

  localparam int DW = 8;
  localparam int N  = 2;
`ifdef DIV_ARBITER_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [DW-1:0] resp_quot;
  logic [DW-1:0] resp_rem;
`ifdef DIV_ARBITER_DBZ_EN
  logic          resp_dbz;
`endif

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  div_arbiter #(
    .DATAWIDTH(DW),
    .NREQ(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_quot (resp_quot),
    .resp_rem  (resp_rem)
`ifdef DIV_ARBITER_DBZ_EN
    ,
    .resp_dbz  (resp_dbz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] m, input int rr);
    for (int k = 0; k < N; k++) begin
      if (m[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  task automatic run_op(input logic [1:0] m,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        input int stall);
    int g;
    int lat;
    int busy_rdy;
    int exp_lat;
    logic [7:0] ea, eb, eq, er;
    logic [16:0] snap;
    g  = pick(m, rr_m);
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    eq = (eb == 0) ? 8'hff : ea / eb;
    er = (eb == 0) ? ea : ea % eb;
    exp_lat = (eb == 0 && DBZ) ? 1 : DW + 1;
    @(posedge clk); #1;
    req_valid  = m;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
    resp_ready = 1'b0;
    @(negedge clk);
    chk("grant", req_ready, 32'd1 << g);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready != '0) busy_rdy++;
    end while (!resp_valid && lat < 40);
    chk("busy_ready", busy_rdy, 0);
    chk("latency", lat, exp_lat);
    chk("id", resp_id, g);
    chk("quot", resp_quot, eq);
    chk("rem", resp_rem, er);
`ifdef DIV_ARBITER_DBZ_EN
    chk("dbz", resp_dbz, eb == 0);
`endif
    snap = {resp_id, resp_quot, resp_rem};
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(negedge clk);
      chk("hold", {resp_valid, resp_id, resp_quot, resp_rem}, {1'b1, snap});
      chk("hold_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_hs", resp_valid, 1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("idle", resp_valid, 0);
    rr_m = (g + 1) % N;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int seen;
    logic [1:0] m;
    logic [7:0] a0, b0, a1, b1;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_quot", resp_quot, 0);
    chk("rst_rem", resp_rem, 0);
    chk("rst_ready", req_ready, 0);
`ifdef DIV_ARBITER_DBZ_EN
    chk("rst_dbz", resp_dbz, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters valid: order 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 8'd100, 8'd7, 8'(40 + i), 8'd6, 0);
    end
    run_op(2'b01, 8'd100, 8'd7, 8'd0, 8'd0, 0);
    run_op(2'b01, 8'd55, 8'd0, 8'd0, 8'd0, 0);
    run_op(2'b10, 8'd0, 8'd0, 8'd200, 8'd3, 5);
    run_op(2'b10, 8'd255, 8'd1, 8'd255, 8'd255, 1);

    for (int i = 0; i < 30; i++) begin
      m  = 2'($urandom_range(1, 3));
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      b0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
      run_op(m, a0, b0, a1, b1, int'($urandom_range(0, 3)));
    end

    // Abort an operation with reset mid-DIVIDE, starting from rr=1
    run_op(2'b01, 8'd9, 8'd2, 8'd0, 8'd0, 0);
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a = {8'd0, 8'd77};
    req_b = {8'd0, 8'd5};
    @(negedge clk);
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_quot", resp_quot, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m = 0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("no_resp", seen, 0);
    run_op(2'b11, 8'd1, 8'd1, 8'd2, 8'd2, 0);
    run_op(2'b10, 8'd0, 8'd0, 8'd3, 8'd200, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 Parameter NREQ, default 2: number of requesters sharing the divider; legal range 2..8.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*DATAWIDTH  dividends; requester i occupies slice [i*DATAWIDTH +: DATAWIDTH].
REQ-008 req_b  input  NREQ*DATAWIDTH  divisors; packed the same way as req_a.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_id  output  max(1,$clog2(NREQ))  index of the requester that owns the result.
REQ-012 resp_quot  output  DATAWIDTH  unsigned quotient.
REQ-013 resp_rem  output  DATAWIDTH  unsigned remainder.
REQ-014 resp_dbz  output  1  divide-by-zero flag; present only when DIV_ARBITER_DBZ_EN is defined.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, DIVIDE, RESP.
REQ-016 In IDLE, when any req_valid is high, the block SHALL grant exactly one requester, using round-robin order that starts the search at pointer rr.
REQ-017 req_ready[g] SHALL be high combinationally only in IDLE and only for the granted index g; the operands are latched and the handshake completes in that same cycle.
REQ-018 After the handshake the FSM SHALL enter DIVIDE and perform unsigned restoring division, one quotient bit per cycle, for exactly DATAWIDTH cycles.
REQ-019 After DIVIDE the FSM SHALL enter RESP and assert resp_valid; for a handshake in cycle T, resp_valid first rises in cycle T+DATAWIDTH+1.
REQ-020 In RESP, resp_id, resp_quot, resp_rem and resp_dbz SHALL hold stable until the cycle in which resp_valid and resp_ready are both high.
REQ-021 On that response handshake the FSM SHALL return to IDLE and set rr to (g+1) mod NREQ.
REQ-022 No new request SHALL be accepted before the response handshake: one operation in flight, and req_ready is all zeros outside IDLE.
REQ-023 A request that is withdrawn in IDLE before its grant SHALL be ignored, and rr SHALL be unchanged.
REQ-024 For a zero divisor, the results SHALL be quot = all ones and rem = a.
REQ-025 The results SHALL satisfy a = quot*b + rem and rem < b for every b != 0.
REQ-026 In IDLE and DIVIDE, resp_valid SHALL be 0.
REQ-027 In IDLE and DIVIDE, the resp_* data outputs SHALL hold their last value.

Reset
REQ-028 While Rst is high, the block SHALL hold: FSM in IDLE, rr=0, resp_valid=0, resp_id=0, resp_quot=0, resp_rem=0, resp_dbz=0.
REQ-029 An operation in DIVIDE or RESP when reset is asserted SHALL be discarded, and no response is issued for it.

Configuration
REQ-030 With DIV_ARBITER_DBZ_EN defined:
- a zero divisor SHALL bypass DIVIDE and go to RESP in the next cycle, so latency = 1;
- resp_dbz SHALL be set to 1 for a zero divisor and 0 otherwise.
REQ-031 Without DIV_ARBITER_DBZ_EN defined:
- the resp_dbz port SHALL be absent;
- a zero divisor SHALL take the full DATAWIDTH-cycle DIVIDE path;
- the results SHALL still follow REQ-024.

Structure
REQ-032 Shared package div_arbiter_pkg SHALL hold:
- the FSM state typedef (IDLE/DIVIDE/RESP);
- the round-robin pointer width function.
REQ-033 The iteration datapath SHALL live in sub-module div_seq, with ports: start, a, b, busy, done, quot, rem.
REQ-034 div_arbiter SHALL contain only the arbitration logic, the FSM and the response register.

Verification (DATAWIDTH=8, NREQ=2)
REQ-035 Single request on requester 0, a=100, b=7 -> resp_id=0, quot=14, rem=2; resp_valid rises 9 cycles after the handshake.
REQ-036 Both requesters valid from reset, resp_ready=1 -> grant order 0, 1, 0, 1; req_ready is never high on both bits.
REQ-037 a=55, b=0, macro defined -> quot=255, rem=55, resp_dbz=1 one cycle after the handshake; macro undefined -> same quot/rem after 9 cycles.
REQ-038 Result a=200, b=3 (quot=66, rem=2) with resp_ready low for 5 cycles -> outputs stable throughout, req_ready=00 throughout, IDLE resumes after the handshake.
REQ-039 Rst pulsed in the 4th DIVIDE cycle -> no resp_valid; the next request on requester 1 (a=3, b=200) returns quot=0, rem=3, and rr restarts from 0.
